vx_gpr_wb_arbiter: RTL
======================

Name: vx_gpr_wb_arbiter

Overview:
- Shares the single general-purpose register file write port among NUM_REQ writeback sources (ALU, LSU, CSR, ...) using round-robin arbitration.
- Registers the winner and drives the register file write interface: one-hot warp select, rd, data, write enable.
- Sits between the execute/memory stages and the per-warp register file instances.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- NUM_WARPS, 8, number of warps; sets the one-hot warp select width (power of 2).
- WARP_W, $clog2(NUM_WARPS), warp id width (derived, not overridable).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester writeback valid.
- req_ready  out  NUM_REQ  per-requester grant; a transfer happens when valid and ready are both high.
- req_warp  in  NUM_REQ*WARP_W  warp id, packed, requester i at [i*WARP_W +: WARP_W].
- req_rd  in  NUM_REQ*5  destination register.
- req_wr  in  NUM_REQ  instruction writes a register.
- req_data  in  NUM_REQ*32  writeback data.
- out_valid  out  1  register file write strobe.
- out_wb_warp  out  NUM_WARPS  one-hot warp select.
- out_rd  out  5  destination register.
- out_data  out  32  write data.
- perf_conflicts  out  32  count of cycles with 2 or more req_valid bits high.

Behaviour:
- Reset (async, reset_n=0): out_valid=0, out_wb_warp=0, out_rd=0, out_data=0, perf_conflicts=0, rr_ptr=0. req_ready is combinational and is all-zero while reset_n=0.
- Grant: combinational round-robin. Search starts at rr_ptr and wraps modulo NUM_REQ. The first requester with valid high gets ready=1. At most one ready bit is high per cycle.
- rr_ptr update: on a grant to index g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Output stage: one register, always enabled, no backpressure (the register file accepts every cycle). Latency is 1 cycle: a grant in cycle N produces out_* in cycle N+1.
- out_valid = granted & req_wr & (req_rd != 0). A granted request with wr=0 or rd=0 is consumed but produces out_valid=0, so x0 is never written.
- When out_valid=0, out_wb_warp is 0. out_rd and out_data hold their last values.
- out_wb_warp = one-hot decode of the granted warp id, masked by out_valid.
- Requests with the same warp and rd from two requesters serialize in grant order. No merging.
- A requester that drops valid before being granted is not tracked (no bookkeeping). Payload must stay stable while valid is high and ready is low.
- perf_conflicts: increments by 1 when popcount(req_valid) >= 2, and saturates at 32'hFFFF_FFFF.
- Asserting reset mid-operation discards any registered output immediately (out_valid=0 asynchronously).
- Fairness bound: a continuously valid requester is granted within NUM_REQ cycles.

Optional Feature:
- Macro VX_WB_FIXED_PRIO0_EN.
- Defined: requester 0 has absolute priority. When req_valid[0]=1 it is always granted, and rr_ptr is not updated on that grant. Round-robin applies only among requesters 1..NUM_REQ-1 when req_valid[0]=0.
- Not defined: pure round-robin over all requesters, as above.

Decomposition:
- Shared package vx_wb_pkg holds:
  - the wb_req_t struct {warp, rd, wr, data};
  - the constant GPR_ZERO = 5'd0;
  - a function onehot_warp(id).
- One natural sub-module, vx_rr_arbiter. Parameter N; inputs req[N], ptr; outputs grant[N] (one-hot), grant_idx, any. It is reusable by other shared-resource arbiters.

Test Plan:
- Reset: hold reset_n=0 with all req_valid=1. Expect ready=0 and out_valid=0. Release reset_n, then grant requester 0 in the first cycle; out_valid=1 the next cycle.
- Single write: requester 1 with warp=3, rd=10, wr=1, data=32'hDEADBEEF. Next cycle: out_valid=1, out_wb_warp=8'b0000_1000, out_rd=10, out_data=32'hDEADBEEF.
- Round-robin: all 3 requesters continuously valid for 6 cycles. Grants follow 0,1,2,0,1,2. perf_conflicts=6.
- x0 filter: requester 2 with rd=0, wr=1. It is granted (ready=1), but out_valid=0 and out_wb_warp=0 the next cycle. rr_ptr advances to 0.
- wr=0 plus contention: req0 has wr=0 and req1 is valid with rd=5. req0 is granted with no write. req1 is granted the next cycle, giving out_valid=1 with out_rd=5.
- VX_WB_FIXED_PRIO0_EN: req0 and req2 valid for 3 cycles. req0 is granted in all 3 cycles. Then drop req0: req2 is granted.

Source files
------------

// File: rtl/vx_wb_pkg.sv
// Shared types and helpers for the GPR writeback arbiter.
// The request payload is sized for up to 32 warps so one struct serves every configuration.
package vx_wb_pkg;

  localparam int unsigned WB_MAX_WARPS = 32;
  localparam int unsigned WB_WARP_ID_W = 5;

  localparam logic [4:0] GPR_ZERO = 5'd0;

  typedef struct packed {
    logic [WB_WARP_ID_W-1:0] warp;
    logic [4:0]              rd;
    logic                    wr;
    logic [31:0]             data;
  } wb_req_t;

  function automatic logic [WB_MAX_WARPS-1:0] onehot_warp(input logic [WB_WARP_ID_W-1:0] id);
    onehot_warp     = '0;
    onehot_warp[id] = 1'b1;
  endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps modulo N.
// Returns a one-hot grant, its index, and whether any request was granted.
module vx_rr_arbiter #(
  parameter int unsigned  N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // ptr is always below N, so one subtraction is enough to wrap
      w_sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (w_sum >= (IDX_W + 1)'(N)) begin
        w_sum = w_sum - (IDX_W + 1)'(N);
      end
      w_idx = w_sum[IDX_W-1:0];
      if (!any && req[w_idx]) begin
        any          = 1'b1;
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/vx_gpr_wb_arbiter.sv
// Round-robin arbiter sharing the GPR file write port among writeback sources.
// Define VX_WB_FIXED_PRIO0_EN to give requester 0 absolute priority over the round-robin.
module vx_gpr_wb_arbiter
  import vx_wb_pkg::*;
#(
  parameter int unsigned  NUM_REQ   = 3,
  parameter int unsigned  NUM_WARPS = 8,
  localparam int unsigned WARP_W    = $clog2(NUM_WARPS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*WARP_W-1:0]   req_warp,
  input  logic [NUM_REQ*5-1:0]        req_rd,
  input  logic [NUM_REQ-1:0]          req_wr,
  input  logic [NUM_REQ*32-1:0]       req_data,
  output logic                        out_valid,
  output logic [NUM_WARPS-1:0]        out_wb_warp,
  output logic [4:0]                  out_rd,
  output logic [31:0]                 out_data,
  output logic [31:0]                 perf_conflicts
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  wb_req_t                 w_req [NUM_REQ];
  wb_req_t                 w_sel;
  logic [NUM_REQ-1:0]      w_arb_req;
  logic [NUM_REQ-1:0]      w_arb_grant;
  logic [IDX_W-1:0]        w_arb_idx;
  logic                    w_arb_any;
  logic [IDX_W-1:0]        w_ptr_rr_next;
  logic [NUM_REQ-1:0]      w_grant;
  logic                    w_any;
  logic [IDX_W-1:0]        w_ptr_d;
  logic                    w_wen;
  logic [WB_MAX_WARPS-1:0] w_onehot;
  logic [3:0]              w_vcnt;
  logic                    w_conflict;

  logic [IDX_W-1:0]        r_ptr;
  logic                    r_valid;
  logic [NUM_WARPS-1:0]    r_wb_warp;
  logic [4:0]              r_rd;
  logic [31:0]             r_data;
  logic [31:0]             r_conf;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_req[i].warp = WB_WARP_ID_W'(req_warp[i*WARP_W +: WARP_W]);
      w_req[i].rd   = req_rd[i*5 +: 5];
      w_req[i].wr   = req_wr[i];
      w_req[i].data = req_data[i*32 +: 32];
    end
  end

`ifdef VX_WB_FIXED_PRIO0_EN
  // Requester 0 never competes in the round-robin; it preempts it instead.
  assign w_arb_req = {req_valid[NUM_REQ-1:1], 1'b0};
`else
  assign w_arb_req = req_valid;
`endif

  vx_rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req       (w_arb_req),
    .ptr       (r_ptr),
    .grant     (w_arb_grant),
    .grant_idx (w_arb_idx),
    .any       (w_arb_any)
  );

  assign w_ptr_rr_next = (w_arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_arb_idx + 1'b1;

  always_comb begin
    w_grant = w_arb_grant;
    w_any   = w_arb_any;
    w_ptr_d = w_arb_any ? w_ptr_rr_next : r_ptr;
`ifdef VX_WB_FIXED_PRIO0_EN
    if (req_valid[0]) begin
      w_grant = NUM_REQ'(1);
      w_any   = 1'b1;
      w_ptr_d = r_ptr;
    end
`endif
  end

  assign req_ready = w_grant & {NUM_REQ{reset_n}};

  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel = w_req[i];
      end
    end
  end

  // Consumed requests with wr=0 or rd=x0 still retire, but never reach the register file
  assign w_wen    = w_any && w_sel.wr && (w_sel.rd != GPR_ZERO);
  assign w_onehot = onehot_warp(w_sel.warp);

  always_comb begin
    w_vcnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_vcnt = w_vcnt + 4'(req_valid[i]);
    end
  end

  assign w_conflict = (w_vcnt >= 4'd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr     <= '0;
      r_valid   <= 1'b0;
      r_wb_warp <= '0;
      r_rd      <= '0;
      r_data    <= '0;
      r_conf    <= '0;
    end else begin
      r_ptr     <= w_ptr_d;
      r_valid   <= w_wen;
      r_wb_warp <= w_wen ? w_onehot[NUM_WARPS-1:0] : '0;
      if (w_wen) begin
        r_rd   <= w_sel.rd;
        r_data <= w_sel.data;
      end
      if (w_conflict && (r_conf != 32'hFFFF_FFFF)) begin
        r_conf <= r_conf + 32'd1;
      end
    end
  end

  assign out_valid      = r_valid;
  assign out_wb_warp    = r_wb_warp;
  assign out_rd         = r_rd;
  assign out_data       = r_data;
  assign perf_conflicts = r_conf;

endmodule
